// File: rtl/viterbi_pkg.sv
// viterbi_pkg: trellis dimensions, encoder FSM states and table lookup helpers
// shared by the convolutional encoder and decoder-side checkers.
`default_nettype none

package viterbi_pkg;

    localparam int ENC_K     = 1;
    localparam int ENC_M     = 3;
    localparam int ENC_N     = 2;
    localparam int S_BITS    = ENC_M - ENC_K;
    localparam int ROW_NS    = (2**ENC_K) * S_BITS;
    localparam int ROW_OUT   = (2**ENC_K) * ENC_N;
    localparam int NS_TBL_W  = (2**S_BITS) * ROW_NS;
    localparam int OUT_TBL_W = (2**S_BITS) * ROW_OUT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_t;

    // Input 0 sits at the top of each row, so entry j starts (2**k-1-j) fields above the row base.
    function automatic logic [S_BITS-1:0] ns_lookup(
        input logic [NS_TBL_W-1:0] tbl,
        input logic [S_BITS-1:0]   st,
        input logic [ENC_K-1:0]    sym
    );
        int off;
        off = int'(st) * ROW_NS + ((2**ENC_K) - 1 - int'(sym)) * S_BITS;
        return S_BITS'(tbl >> off);
    endfunction

    function automatic logic [ENC_N-1:0] out_lookup(
        input logic [OUT_TBL_W-1:0] tbl,
        input logic [S_BITS-1:0]    st,
        input logic [ENC_K-1:0]     sym
    );
        int off;
        off = int'(st) * ROW_OUT + ((2**ENC_K) - 1 - int'(sym)) * ENC_N;
        return ENC_N'(tbl >> off);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_encoder_trellis_lookup.sv
// trellis_lookup: combinational (state, symbol) -> (next state, code word)
// lookup into the flattened Next State / Output tables.
`default_nettype none

module trellis_lookup #(
    parameter int k = 1,
    parameter int m = 3,
    parameter int n = 2
) (
    input  logic [m-k-1:0]                     state,
    input  logic [k-1:0]                       sym,
    input  logic [(2**(m-k))*(2**k)*(m-k)-1:0] next_state_table,
    input  logic [(2**(m-k))*(2**k)*n-1:0]     output_table,
    output logic [m-k-1:0]                     next_state,
    output logic [n-1:0]                       code
);

    localparam int SB = m - k;
    localparam int WS = (2**k) * SB;
    localparam int WO = (2**k) * n;

    int ns_off;
    int out_off;

    always_comb begin
        ns_off     = int'(state) * WS + ((2**k) - 1 - int'(sym)) * SB;
        out_off    = int'(state) * WO + ((2**k) - 1 - int'(sym)) * n;
        next_state = SB'(next_state_table >> ns_off);
        code       = n'(output_table >> out_off);
    end

endmodule

`default_nettype wire

// File: rtl/conv_encoder.sv
// conv_encoder: table-driven convolutional encoder producing FRAME_LEN data
// code words plus TAIL_SYMS zero-input tail words per frame.
`default_nettype none

module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int k         = ENC_K,
    parameter int m         = ENC_M,
    parameter int n         = ENC_N,
    parameter int FRAME_LEN = 8,
    parameter int TAIL_SYMS = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [(2**(m-k))*(2**k)*(m-k)-1:0]  next_state_table,
    input  logic [(2**(m-k))*(2**k)*n-1:0]      output_table,
    input  logic                                load,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [k-1:0]                        in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [n-1:0]                        out_data,
    output logic                                out_last,
    output logic [m-k-1:0]                      final_state,
    output logic                                err
);

    localparam int SB   = m - k;
    localparam int MAXC = (FRAME_LEN > TAIL_SYMS) ? FRAME_LEN : TAIL_SYMS;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] FL_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TL_LAST = CW'((TAIL_SYMS > 0) ? TAIL_SYMS - 1 : 0);

    enc_state_t      fsm;
    logic [SB-1:0]   cur_state;
    logic [CW-1:0]   sym_cnt;
    logic            adv;
    logic            encode;
    logic [SB-1:0]   lk_state;
    logic [k-1:0]    lk_sym;
    logic [SB-1:0]   nxt;
    logic [n-1:0]    code;

    // Every frame starts from the zero state, whatever cur_state was left holding.
    always_comb begin
        adv      = !out_valid || out_ready;
        in_ready = 1'b0;
        case (fsm)
            IDLE:    in_ready = !load && adv;
            DATA:    in_ready = adv;
            default: in_ready = 1'b0;
        endcase
        lk_state = (fsm == IDLE) ? '0 : cur_state;
        lk_sym   = (fsm == TAIL) ? '0 : in_data;
        encode   = (fsm == TAIL) ? adv : (in_valid && in_ready);
    end

    trellis_lookup #(
        .k (k),
        .m (m),
        .n (n)
    ) u_lookup (
        .state            (lk_state),
        .sym              (lk_sym),
        .next_state_table (next_state_table),
        .output_table     (output_table),
        .next_state       (nxt),
        .code             (code)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm         <= IDLE;
            cur_state   <= '0;
            sym_cnt     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            final_state <= '0;
            err         <= 1'b0;
        end else begin
            if (load && fsm != IDLE) begin
                err <= 1'b1;
            end
            if (encode) begin
                out_valid <= 1'b1;
                out_data  <= code;
                out_last  <= 1'b0;
                cur_state <= nxt;
                case (fsm)
                    IDLE: begin
                        if (FRAME_LEN == 1 && TAIL_SYMS == 0) begin
                            out_last    <= 1'b1;
                            final_state <= nxt;
                            sym_cnt     <= CW'(1);
                        end else if (FRAME_LEN == 1) begin
                            fsm     <= TAIL;
                            sym_cnt <= '0;
                        end else begin
                            fsm     <= DATA;
                            sym_cnt <= CW'(1);
                        end
                    end
                    DATA: begin
                        if (sym_cnt == FL_LAST) begin
                            sym_cnt <= '0;
                            if (TAIL_SYMS == 0) begin
                                out_last    <= 1'b1;
                                final_state <= nxt;
                                fsm         <= IDLE;
                            end else begin
                                fsm <= TAIL;
                            end
                        end else begin
                            sym_cnt <= sym_cnt + CW'(1);
                        end
                    end
                    TAIL: begin
                        if (sym_cnt == TL_LAST) begin
                            out_last    <= 1'b1;
                            final_state <= nxt;
                            sym_cnt     <= '0;
                            fsm         <= IDLE;
                        end else begin
                            sym_cnt <= sym_cnt + CW'(1);
                        end
                    end
                    default: fsm <= IDLE;
                endcase
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
